display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an NDIG-digit hex display sharing one 7-segment bus.
- Accepts a new display word through a valid/ready handshake and holds it in a pending buffer.
- Commits the word to the display only at frame boundaries, so a frame never shows a mix of old and new digits.
- Per digit slot: decodes one nibble with hex7seg, drives one digit select and inserts dead time against ghosting.
- Supports leading-zero suppression, a per-digit blank mask and a per-digit blink mask.

---
 rtl/display_scan_ctrl_pkg.sv | 24 ++
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl_hex7seg.sv | 32 +++
 rtl/display_scan_ctrl.sv | 108 ++++++++++
 tb/tb_display_scan_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the display scan controller.
// Pure declarations: no latency, no flow control.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         MAX_DIG   = 16;

  typedef logic [3:0] nibble_t;

  // Bit d is set when d>0 and every nibble from d up to ndig-1 is zero.
  function automatic logic [MAX_DIG-1:0] lead_zero_mask(input logic [MAX_DIG*4-1:0] value,
                                                        input int ndig);
    logic zero_above;
    lead_zero_mask = '0;
    zero_above     = 1'b1;
    for (int d = MAX_DIG - 1; d >= 1; d--) begin
      if (d < ndig) begin
        zero_above        = zero_above && (value[d*4 +: 4] == 4'h0);
        lead_zero_mask[d] = zero_above;
      end
    end
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load handshake bundle for the scan controller: one word plus its masks.
// Valid/ready; the word transfers on the cycle both are high.
interface display_scan_ctrl_if #(
  parameter int NDIG = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [NDIG*4-1:0] load_value;
  logic [NDIG-1:0]   load_blank;
  logic [NDIG-1:0]   load_blink;

  modport master (
    output load_valid, load_value, load_blank, load_blink,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_value, load_blank, load_blink,
    output load_ready
  );
endinterface

// File: rtl/display_scan_ctrl_hex7seg.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
// Purely combinational; no flow control.
module hex7seg
  import display_pkg::*;
(
  input  nibble_t    nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed hex display scanner; outputs registered one cycle after prescaler/idx.
// Backpressure: load_ready low while a word is pending; pending commits only at frame end.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  display_scan_ctrl_if.slave  load,
  input  logic                lz_suppress,
  output logic [6:0]          seg,
  output logic [NDIG-1:0]     dig_sel_n,
  output logic                frame_tick
);

  localparam int PW  = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(NDIG);
  localparam int BW  = $clog2(BLINK_FRAMES) + 1;
  localparam int LZW = MAX_DIG * 4;

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic              pend_full;
  logic [NDIG*4-1:0] pend_value, act_value;
  logic [NDIG-1:0]   pend_blank, pend_blink, act_blank, act_blink;
  logic [NDIG-1:0]   lz_mask;
  logic              slot_end, frame_end, accept, digit_blank;
  nibble_t           cur_nib;
  logic [6:0]        cur_seg;

  assign slot_end       = (presc == PW'(SCAN_DIV - 1));
  assign frame_end      = slot_end && (idx == IW'(NDIG - 1));
  assign load.load_ready = ~pend_full;
  assign accept         = load.load_valid && ~pend_full;

  // Zero test looks only at the digit values; the masks never hide a nonzero digit.
  assign lz_mask     = NDIG'(lead_zero_mask(LZW'(act_value), NDIG));
  assign cur_nib     = act_value[{idx, 2'b00} +: 4];
  assign digit_blank = act_blank[idx] | (act_blink[idx] & blink_phase) |
                       (lz_suppress & lz_mask[idx]);

  hex7seg u_hex7seg (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_full   <= 1'b0;
      pend_value  <= '0;
      pend_blank  <= '0;
      pend_blink  <= '0;
      act_value   <= '0;
      act_blank   <= '0;
      act_blink   <= '0;
      seg         <= SEG_BLANK;
      dig_sel_n   <= '1;
      frame_tick  <= 1'b0;
    end else begin
      presc      <= slot_end ? '0 : presc + 1'b1;
      frame_tick <= frame_end;
      if (slot_end) begin
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end

      // Commit needs a full buffer and accept needs an empty one, so they never collide.
      if (frame_end) begin
        if (pend_full) begin
          act_value <= pend_value;
          act_blank <= pend_blank;
          act_blink <= pend_blink;
          pend_full <= 1'b0;
        end
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (accept) begin
        pend_value <= load.load_value;
        pend_blank <= load.load_blank;
        pend_blink <= load.load_blink;
        pend_full  <= 1'b1;
      end

      if (presc < PW'(DEAD)) begin
        seg       <= SEG_BLANK;
        dig_sel_n <= '1;
      end else begin
        seg       <= digit_blank ? SEG_BLANK : cur_seg;
        dig_sel_n <= ~(NDIG'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: time-indexed reference model plus directed/random scenarios.
module tb_display_scan_ctrl;

  localparam int NDIG = 4, SCAN_DIV = 8, DEAD = 2, BF = 2;
  localparam int FRAME = NDIG * SCAN_DIV;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            lz_suppress = 1'b0;
  logic [6:0]      seg;
  logic [NDIG-1:0] dig_sel_n;
  logic            frame_tick;

  display_scan_ctrl_if #(.NDIG(NDIG)) lif ();

  display_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD), .BLINK_FRAMES(BF)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (lif),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dig_sel_n   (dig_sel_n),
    .frame_tick  (frame_tick)
  );

  always #5 clock = ~clock;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: t = cycles since reset release, k = frame boundaries passed.
  int          t, k;
  logic        m_full, m_acc;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pbk, m_pbl, m_abk, m_abl;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_tick, exp_rdy;
  int          checks = 0, passed = 0;

  function automatic logic is_blank(int d);
    return m_abk[d] || (m_abl[d] && ((k / BF) % 2 == 1)) ||
           (lz_suppress && d > 0 && ((m_av >> (4 * d)) == 16'd0));
  endfunction

  task automatic model_reset();
    t = 0; k = 0; m_full = 1'b0; m_acc = 1'b0;
    m_pv = '0; m_av = '0; m_pbk = '0; m_pbl = '0; m_abk = '0; m_abl = '0;
    exp_seg = 7'h7F; exp_dig = 4'hF; exp_tick = 1'b0; exp_rdy = 1'b1;
  endtask

  // Advance one clock from a negedge to the next, updating the model expectations.
  task automatic tick();
    int      p, i;
    logic    bnd;
    logic [3:0] nib;
    p   = t % SCAN_DIV;
    i   = (t / SCAN_DIV) % NDIG;
    bnd = (t % FRAME) == FRAME - 1;
    nib = m_av[4*i +: 4];
    if (p < DEAD) begin
      exp_dig = 4'hF;
      exp_seg = 7'h7F;
    end else begin
      exp_dig = ~(4'(1) << i);
      exp_seg = is_blank(i) ? 7'h7F : hex_tbl[nib];
    end
    exp_tick = bnd;
    m_acc    = lif.load_valid && !m_full;
    @(posedge clock);
    if (bnd) begin
      if (m_full) begin
        m_av = m_pv; m_abk = m_pbk; m_abl = m_pbl; m_full = 1'b0;
      end
      k++;
    end
    if (m_acc) begin
      m_pv = lif.load_value; m_pbk = lif.load_blank; m_pbl = lif.load_blink; m_full = 1'b1;
    end
    exp_rdy = !m_full;
    t++;
    @(negedge clock);
  endtask

  task automatic offer(input logic [15:0] v, input logic [3:0] bk, input logic [3:0] bl,
                       output bit ok);
    lif.load_valid = 1'b1; lif.load_value = v; lif.load_blank = bk; lif.load_blink = bl;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      tick();
      if (m_acc) ok = 1'b1;
    end
    lif.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    offer(16'h9876, 4'h0, 4'h0, ok);
    repeat (13) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {7'h7F, 4'hF, 1'b0, 1'b1})
      $display("FAIL reset_async: got seg=%h dig=%b tick=%b rdy=%b want seg=7f dig=1111 tick=0 rdy=1",
               seg, dig_sel_n, frame_tick, lif.load_ready);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (dig_sel_n !== ((n == 2) ? 4'b1110 : 4'b1111))
        $display("FAIL reset_first_sel cycle %0d: got %b want %b", n, dig_sel_n,
                 (n == 2) ? 4'b1110 : 4'b1111);
      else passed++;
    end
    checks++;
    if (seg !== 7'h40 || lif.load_ready !== 1'b1)
      $display("FAIL reset_discard: got seg=%h rdy=%b want seg=40 rdy=1", seg, lif.load_ready);
    else passed++;
  endtask

  task automatic test_load();
    bit ok, seen;
    logic [6:0] got [NDIG];
    int cnt [NDIG];
    logic [6:0] want [NDIG] = '{7'h78, 7'h08, 7'h24, 7'h79};
    offer(16'h12A7, 4'h0, 4'h0, ok);
    checks++;
    if (!ok) $display("FAIL load_accept: got no accept want accept within 200 cycles");
    else passed++;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      checks++;
      if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {exp_seg, exp_dig, exp_tick, exp_rdy})
        $display("FAIL load_wait: got %h/%b/%b/%b want %h/%b/%b/%b", seg, dig_sel_n, frame_tick,
                 lif.load_ready, exp_seg, exp_dig, exp_tick, exp_rdy);
      else passed++;
      seen = frame_tick;
    end
    for (int d = 0; d < NDIG; d++) begin got[d] = 7'h7F; cnt[d] = 0; end
    repeat (FRAME) begin
      tick();
      checks++;
      if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {exp_seg, exp_dig, exp_tick, exp_rdy})
        $display("FAIL load_frame: got %h/%b/%b/%b want %h/%b/%b/%b", seg, dig_sel_n, frame_tick,
                 lif.load_ready, exp_seg, exp_dig, exp_tick, exp_rdy);
      else passed++;
      for (int d = 0; d < NDIG; d++) if (!dig_sel_n[d]) begin got[d] = seg; cnt[d]++; end
    end
    for (int d = 0; d < NDIG; d++) begin
      checks++;
      if (got[d] !== want[d] || cnt[d] != SCAN_DIV - DEAD)
        $display("FAIL load_digit%0d: got seg=%h sel=%0d want seg=%h sel=%0d", d, got[d], cnt[d],
                 want[d], SCAN_DIV - DEAD);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    offer(16'h1111, 4'h0, 4'h0, ok);
    lif.load_valid = 1'b1; lif.load_value = 16'h2222;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      checks++;
      if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {exp_seg, exp_dig, exp_tick, exp_rdy})
        $display("FAIL b2b_wait: got %h/%b/%b/%b want %h/%b/%b/%b", seg, dig_sel_n, frame_tick,
                 lif.load_ready, exp_seg, exp_dig, exp_tick, exp_rdy);
      else passed++;
      seen = frame_tick;
    end
    checks++;
    if (!ok || !seen || lif.load_ready !== 1'b1)
      $display("FAIL b2b_boundary: got ok=%b tick=%b rdy=%b want 1/1/1", ok, seen, lif.load_ready);
    else passed++;
    tick();
    lif.load_valid = 1'b0;
    checks++;
    if (lif.load_ready !== 1'b0)
      $display("FAIL b2b_second_accept: got rdy=%b want 0", lif.load_ready);
    else passed++;
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {exp_seg, exp_dig, exp_tick, exp_rdy})
        $display("FAIL b2b_run: got %h/%b/%b/%b want %h/%b/%b/%b", seg, dig_sel_n, frame_tick,
                 lif.load_ready, exp_seg, exp_dig, exp_tick, exp_rdy);
      else passed++;
    end
  endtask

  task automatic test_lz();
    bit ok, seen;
    logic [6:0] got [NDIG];
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    logic [6:0] want [2][NDIG] = '{'{7'h40, 7'h12, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
    lz_suppress = 1'b1;
    for (int v = 0; v < 2; v++) begin
      offer(vals[v], 4'h0, 4'h0, ok);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        tick();
        seen = frame_tick;
      end
      for (int d = 0; d < NDIG; d++) got[d] = 7'h00;
      repeat (FRAME) begin
        tick();
        checks++;
        if ({seg, dig_sel_n, frame_tick} !== {exp_seg, exp_dig, exp_tick})
          $display("FAIL lz_frame: got %h/%b/%b want %h/%b/%b", seg, dig_sel_n, frame_tick,
                   exp_seg, exp_dig, exp_tick);
        else passed++;
        for (int d = 0; d < NDIG; d++) if (!dig_sel_n[d]) got[d] = seg;
      end
      for (int d = 0; d < NDIG; d++) begin
        checks++;
        if (!ok || got[d] !== want[v][d])
          $display("FAIL lz_digit%0d value %h: got %h want %h", d, vals[v], got[d], want[v][d]);
        else passed++;
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_blink();
    bit ok, seen;
    logic [6:0] got [NDIG];
    logic lit [8];
    offer(16'h4321, 4'b1000, 4'b0001, ok);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      seen = frame_tick;
    end
    for (int f = 0; f < 8; f++) begin
      repeat (FRAME) begin
        tick();
        checks++;
        if ({seg, dig_sel_n, frame_tick} !== {exp_seg, exp_dig, exp_tick})
          $display("FAIL blink_frame: got %h/%b/%b want %h/%b/%b", seg, dig_sel_n, frame_tick,
                   exp_seg, exp_dig, exp_tick);
        else passed++;
        for (int d = 0; d < NDIG; d++) if (!dig_sel_n[d]) got[d] = seg;
      end
      lit[f] = (got[0] === 7'h79);
      checks++;
      if (!ok || got[3] !== 7'h7F || got[1] !== 7'h24 || (got[0] !== 7'h79 && got[0] !== 7'h7F))
        $display("FAIL blink_steady frame %0d: got d3=%h d1=%h d0=%h want d3=7f d1=24 d0=79|7f",
                 f, got[3], got[1], got[0]);
      else passed++;
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (lit[f + 2] === lit[f])
        $display("FAIL blink_period frame %0d: got lit=%b two frames later want %b", f, lit[f + 2],
                 !lit[f]);
      else passed++;
    end
  endtask

  task automatic test_coincident();
    int n, first, ntick, last;
    n = 0;
    while (!(((t % FRAME) == FRAME - 1) && !m_full) && n < 200) begin
      tick();
      n++;
    end
    lif.load_valid = 1'b1; lif.load_value = 16'hBEEF; lif.load_blank = 4'h0; lif.load_blink = 4'h0;
    tick();
    lif.load_valid = 1'b0;
    checks++;
    if (frame_tick !== 1'b1 || lif.load_ready !== 1'b0)
      $display("FAIL coinc_accept: got tick=%b rdy=%b want tick=1 rdy=0", frame_tick, lif.load_ready);
    else passed++;
    first = -1; last = -1; ntick = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {exp_seg, exp_dig, exp_tick, exp_rdy})
        $display("FAIL coinc_run: got %h/%b/%b/%b want %h/%b/%b/%b", seg, dig_sel_n, frame_tick,
                 lif.load_ready, exp_seg, exp_dig, exp_tick, exp_rdy);
      else passed++;
      if (frame_tick === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        ntick++;
      end
    end
    checks++;
    if (ntick != 2 || first != FRAME - 1 || last - first != FRAME)
      $display("FAIL coinc_tick_spacing: got n=%0d first=%0d last=%0d want n=2 first=%0d last=%0d",
               ntick, first, last, FRAME - 1, 2 * FRAME - 1);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) lz_suppress = 1'($urandom_range(0, 1));
      lif.load_valid = ($urandom_range(0, 5) == 0);
      lif.load_value = 16'($urandom);
      if ($urandom_range(0, 1) == 0) lif.load_value = lif.load_value & 16'h00FF;
      lif.load_blank = 4'($urandom) & 4'($urandom);
      lif.load_blink = 4'($urandom);
      tick();
      checks++;
      if ({seg, dig_sel_n, frame_tick, lif.load_ready} !== {exp_seg, exp_dig, exp_tick, exp_rdy})
        $display("FAIL random cycle %0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, seg, dig_sel_n,
                 frame_tick, lif.load_ready, exp_seg, exp_dig, exp_tick, exp_rdy);
      else passed++;
    end
    lif.load_valid = 1'b0;
  endtask

  initial begin
    lif.load_valid = 1'b0; lif.load_value = '0; lif.load_blank = '0; lif.load_blink = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    test_reset();
    test_load();
    test_back_to_back();
    test_lz();
    test_blink();
    test_coincident();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
